mux_arb_reg: RTL and testbench
==============================

Name: mux_arb_reg

Overview:
- Parametrised successor to the lab 2:1 gate-level selector.
- Merges NCH valid/ready input channels of WIDTH bits onto one registered output.
- Channel choice is either software-driven (sel port) or hardware round-robin.
- Grant is held for a whole packet (until a beat with in_last) and the output is buffered in one register stage.
- Sits between multiple producer stages and a single downstream consumer in the lab datapath.

Parameters:
- WIDTH, 8, data bits per channel.
- NCH, 4, number of input channels (2..16; need not be a power of 2).
- MODE, 0, 0 = select-driven (sel port), 1 = round-robin arbitration.
- SELW (localparam), max(1, clog2(NCH)), width of sel and out_chan.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NCH  per-channel beat valid.
- in_last  in  NCH  per-channel end-of-packet marker, qualified by in_valid.
- in_ready  out  NCH  per-channel accept; at most one bit high.
- sel  in  SELW  requested channel (MODE 0 only; ignored in MODE 1).
- out_data  out  WIDTH  registered output beat.
- out_last  out  1  registered last marker for out_data.
- out_chan  out  SELW  registered source channel of out_data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE, grant=0, rr_ptr=NCH-1.
  - out_valid=0, out_data=0, out_last=0, out_chan=0.
  - in_ready is all 0 while state=IDLE.
  - Reset mid-packet discards the partial packet and any buffered beat.
- FSM states: IDLE, BUSY.
- IDLE:
  - MODE 0: if sel<NCH and in_valid[sel]=1, then grant<=sel and go to BUSY. If sel>=NCH, stay in IDLE (no grant).
  - MODE 1: search channels rr_ptr+1, rr_ptr+2, ... mod NCH. The first channel with in_valid=1 is granted: grant<=ch, rr_ptr<=ch, go to BUSY.
  - No valid candidate: remain in IDLE.
- BUSY:
  - load_en = !out_valid || out_ready.
  - in_ready[grant] = load_en (combinational); all other in_ready bits are 0.
  - Transfer occurs when in_valid[grant] && in_ready[grant]. On transfer: out_data<=channel data, out_last<=in_last[grant], out_chan<=grant, out_valid<=1.
  - Transfer with in_last=1 returns the FSM to IDLE.
  - Granted channel dropping in_valid mid-packet: stay in BUSY and wait, with no timeout.
  - sel changes and other channels' valids are ignored until IDLE.
- Output register:
  - If out_valid && !out_ready, out_data, out_last and out_chan hold stable.
  - If out_ready=1 and no transfer this cycle, out_valid<=0.
  - Full throughput: one beat per cycle while BUSY with out_ready=1.
- Latency:
  - in_valid rises in IDLE at cycle 0; grant is registered at edge 1.
  - First in_ready is at cycle 1; out_valid is at cycle 2.
  - Each packet costs exactly one IDLE bubble cycle after its last beat.
- Simultaneous events:
  - Last beat accepted and a new request present in the same cycle: the new grant is evaluated in the following IDLE cycle, not the same cycle.
  - The output register may still drain during IDLE.
- Widths: out_chan is zero-extended to SELW; no arithmetic beyond the mod-NCH pointer wrap, where NCH-1 wraps to 0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=4'b1111 -> out_valid=0 and in_ready=0 throughout; after release (MODE 1), channel 0 is granted first and out_chan=0.
- MODE 0, sel=2, channel 2 sends 0x11, 0x22, 0x33 (last on 0x33), sel switched to 1 after the first beat -> out_data 0x11/0x22/0x33 on consecutive cycles, out_chan=2, out_last=1 only on 0x33; channel 1 is granted only after the IDLE bubble.
- MODE 1, all four channels continuously valid with single-beat packets (in_last=1), out_ready=1 -> out_chan sequence 0,1,2,3,0,1 with one bubble between beats.
- Backpressure: mid-packet, out_ready=0 for 3 cycles -> out_data/out_last/out_chan stable, in_ready[grant]=0, no beat lost or duplicated; stream resumes with the next beat when out_ready=1.
- Reset mid-packet: assert rst_n=0 after beat 2 of a 4-beat packet -> next cycle out_valid=0, state IDLE, rr_ptr=NCH-1; the remaining beats are not forwarded until a new grant.
- NCH=3, MODE 0, sel=3 with in_valid=3'b111 for 10 cycles -> no grant, in_ready=0, out_valid=0; setting sel=1 then grants channel 1.

Source files
------------

// File: rtl/mux_arb_reg_if.sv
// Handshake bundle for mux_arb_reg: NCH producer channels in, one registered beat out.
interface mux_arb_reg_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_last;
  logic [NCH-1:0]       in_ready;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic                 out_last;
  logic [SELW-1:0]      out_chan;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, in_last, sel, out_ready,
    input  in_ready, out_data, out_last, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, sel, out_ready,
    output in_ready, out_data, out_last, out_chan, out_valid
  );
endinterface

// File: rtl/mux_arb_reg.sv
// Packet-granular NCH:1 channel merger with select or round-robin choice and a
// single registered output stage.
//
// state | meaning
// IDLE  | no grant held; choose the next channel
// BUSY  | grant held until a beat marked last transfers
module mux_arb_reg #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int MODE  = 0,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_arb_reg_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  rr_ptr;

  logic             load_en;
  logic             xfer;
  logic             cur_valid;
  logic             cur_last;
  logic [WIDTH-1:0] cur_data;
  logic             sel_hit;
  logic             hi_hit, lo_hit, rr_hit;
  logic [SELW-1:0]  hi_pick, lo_pick, rr_pick;

  assign load_en = !bus.out_valid || bus.out_ready;
  assign xfer    = (state == BUSY) && cur_valid && load_en;
  assign rr_hit  = hi_hit || lo_hit;
  assign rr_pick = hi_hit ? hi_pick : lo_pick;

  always_comb begin
    cur_valid    = 1'b0;
    cur_last     = 1'b0;
    cur_data     = '0;
    sel_hit      = 1'b0;
    bus.in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant == SELW'(i)) begin
        cur_valid = bus.in_valid[i];
        cur_last  = bus.in_last[i];
        cur_data  = bus.in_data[i*WIDTH +: WIDTH];
        if (state == BUSY) bus.in_ready[i] = load_en;
      end
      if (bus.sel == SELW'(i) && bus.in_valid[i]) sel_hit = 1'b1;
    end
  end

  // Channels above rr_ptr win over those at or below it; descending scan
  // leaves the lowest index of each group as the pick.
  always_comb begin
    hi_hit  = 1'b0;
    lo_hit  = 1'b0;
    hi_pick = '0;
    lo_pick = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        if (SELW'(i) > rr_ptr) begin
          hi_hit  = 1'b1;
          hi_pick = SELW'(i);
        end else begin
          lo_hit  = 1'b1;
          lo_pick = SELW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= '0;
      rr_ptr        <= SELW'(NCH - 1);
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_chan  <= '0;
    end else begin
      if (xfer) begin
        bus.out_data  <= cur_data;
        bus.out_last  <= cur_last;
        bus.out_chan  <= grant;
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (MODE == 0) begin
            if (sel_hit) begin
              grant <= bus.sel;
              state <= BUSY;
            end
          end else if (rr_hit) begin
            grant  <= rr_pick;
            rr_ptr <= rr_pick;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (xfer && cur_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed bench for mux_arb_reg: select mode, round-robin, backpressure,
// reset handling and a non-power-of-2 channel count.
module tb_mux_arb_reg;

  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mux_arb_reg_if #(.WIDTH(8), .NCH(4)) b0 ();
  mux_arb_reg_if #(.WIDTH(8), .NCH(4)) b1 ();
  mux_arb_reg_if #(.WIDTH(8), .NCH(3)) b2 ();

  mux_arb_reg #(.WIDTH(8), .NCH(4), .MODE(0)) u0 (.clk(clk), .rst_n(rst0), .bus(b0));
  mux_arb_reg #(.WIDTH(8), .NCH(4), .MODE(1)) u1 (.clk(clk), .rst_n(rst1), .bus(b1));
  mux_arb_reg #(.WIDTH(8), .NCH(3), .MODE(0)) u2 (.clk(clk), .rst_n(rst2), .bus(b2));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    b0.in_data = '0; b0.in_valid = '0; b0.in_last = '0; b0.sel = '0; b0.out_ready = 1'b1;
    b2.in_data = '0; b2.in_valid = '0; b2.in_last = '0; b2.sel = '0; b2.out_ready = 1'b1;
    b1.sel = '0; b1.out_ready = 1'b1;
    b1.in_valid = 4'hF;
    b1.in_last  = 4'hF;
    b1.in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Reset held two cycles with every channel requesting
    for (int c = 0; c < 2; c++) begin
      step(); #2;
      chk("rst_out_valid", b1.out_valid, 0);
      chk("rst_in_ready", b1.in_ready, 0);
    end
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    step(); #2;
    chk("rr_first_ready", b1.in_ready, 4'b0001);
    step(); #2;
    chk("rr_first_valid", b1.out_valid, 1);
    chk("rr_first_chan", b1.out_chan, 0);
    chk("rr_first_data", b1.out_data, 8'hA0);
    chk("rr_first_last", b1.out_last, 1);

    // Round-robin rotation with one bubble between single-beat packets
    for (int n = 1; n < 6; n++) begin
      step(); #2;
      chk("rr_bubble", b1.out_valid, 0);
      step(); #2;
      chk("rr_valid", b1.out_valid, 1);
      chk("rr_chan", b1.out_chan, n % 4);
      chk("rr_data", b1.out_data, 8'hA0 + (n % 4));
    end

    // Reset after beat 2 of a 4-beat packet on channel 2
    b1.in_valid = '0;
    rst1 = 1'b0;
    step(); #2;
    rst1 = 1'b1;
    b1.in_data  = '0;
    b1.in_data[16 +: 8] = 8'h01;
    b1.in_last  = '0;
    b1.in_valid = 4'b0100;
    step(); #2;
    chk("mid_grant_ready", b1.in_ready, 4'b0100);
    step();
    b1.in_data[16 +: 8] = 8'h02;
    #2;
    chk("mid_beat1", b1.out_data, 8'h01);
    step();
    b1.in_data[16 +: 8] = 8'h03;
    rst1 = 1'b0;
    #2;
    chk("mid_beat2", b1.out_data, 8'h02);
    step(); #2;
    chk("mid_rst_valid", b1.out_valid, 0);
    chk("mid_rst_ready", b1.in_ready, 0);
    rst1 = 1'b1;
    b1.in_data[24 +: 8] = 8'h33;
    b1.in_last  = 4'b1000;
    b1.in_valid = 4'b1100;
    step(); #2;
    chk("mid_regrant_ptr", b1.in_ready, 4'b0100);
    step(); #2;
    chk("mid_resume_data", b1.out_data, 8'h03);
    chk("mid_resume_chan", b1.out_chan, 2);
    b1.in_valid = '0;

    // Select mode: sel switched mid-packet must not move the grant
    b0.sel = 2'd2;
    b0.in_data[8 +: 8]  = 8'h55;
    b0.in_data[16 +: 8] = 8'h11;
    b0.in_last  = 4'b0010;
    b0.in_valid = 4'b0110;
    step(); #2;
    chk("sel_ready", b0.in_ready, 4'b0100);
    step();
    b0.sel = 2'd1;
    b0.in_data[16 +: 8] = 8'h22;
    #2;
    chk("sel_beat1", b0.out_data, 8'h11);
    chk("sel_chan1", b0.out_chan, 2);
    chk("sel_last1", b0.out_last, 0);
    chk("sel_hold_ready", b0.in_ready, 4'b0100);
    step();
    b0.in_data[16 +: 8] = 8'h33;
    b0.in_last = 4'b0110;
    #2;
    chk("sel_beat2", b0.out_data, 8'h22);
    chk("sel_last2", b0.out_last, 0);
    step();
    b0.in_valid = 4'b0010;
    #2;
    chk("sel_beat3", b0.out_data, 8'h33);
    chk("sel_last3", b0.out_last, 1);
    chk("sel_chan3", b0.out_chan, 2);
    chk("sel_bubble_ready", b0.in_ready, 0);
    step(); #2;
    chk("sel_drain", b0.out_valid, 0);
    chk("sel_ch1_ready", b0.in_ready, 4'b0010);
    step(); #2;
    chk("sel_ch1_chan", b0.out_chan, 1);
    chk("sel_ch1_data", b0.out_data, 8'h55);

    // Backpressure for three cycles mid-packet on channel 0
    b0.sel = 2'd0;
    b0.in_last = '0;
    b0.in_data[0 +: 8] = 8'h40;
    b0.in_valid = 4'b0001;
    step();
    step();
    b0.in_data[0 +: 8] = 8'h41;
    step();
    b0.in_data[0 +: 8] = 8'h42;
    b0.out_ready = 1'b0;
    #2;
    chk("bp_beat", b0.out_data, 8'h41);
    chk("bp_ready_low", b0.in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      step(); #2;
      chk("bp_hold_data", b0.out_data, 8'h41);
      chk("bp_hold_valid", b0.out_valid, 1);
      chk("bp_hold_chan", b0.out_chan, 0);
      chk("bp_hold_last", b0.out_last, 0);
      chk("bp_hold_ready", b0.in_ready, 0);
    end
    b0.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", b0.in_ready, 4'b0001);
    step();
    b0.in_data[0 +: 8] = 8'h43;
    b0.in_last = 4'b0001;
    #2;
    chk("bp_next_beat", b0.out_data, 8'h42);
    step(); #2;
    chk("bp_last_beat", b0.out_data, 8'h43);
    chk("bp_last_flag", b0.out_last, 1);
    b0.in_valid = '0;

    // Three channels: out-of-range select never grants
    b2.in_data  = {8'hC2, 8'hC1, 8'hC0};
    b2.in_last  = 3'b111;
    b2.in_valid = 3'b111;
    b2.sel      = 2'd3;
    for (int c = 0; c < 10; c++) begin
      step(); #2;
      chk("oor_ready", b2.in_ready, 0);
      chk("oor_valid", b2.out_valid, 0);
    end
    b2.sel = 2'd1;
    step(); #2;
    chk("oor_grant", b2.in_ready, 3'b010);
    step(); #2;
    chk("oor_out_valid", b2.out_valid, 1);
    chk("oor_out_chan", b2.out_chan, 1);
    chk("oor_out_data", b2.out_data, 8'hC1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
